// File: rtl/alu.sv
// Accumulator ALU: executes one 12-bit instruction per enabled clock edge.
// An invalid opcode latches a sticky error state that only reset clears.
module alu (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_wen,
    output logic [7:0]  result
);

    typedef enum logic {
        StReady,
        StError
    } state_e;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLdi = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpNot = 4'h4;
    localparam logic [3:0] OpAnd = 4'h5;
    localparam logic [3:0] OpIor = 4'h6;
    localparam logic [3:0] OpXor = 4'h7;
    localparam logic [3:0] OpShl = 4'h8;
    localparam logic [3:0] OpShr = 4'h9;

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;

    logic [3:0] opcode;
    logic [7:0] imm;
    logic       shift_oob;

    assign opcode    = inst[11:8];
    assign imm       = inst[7:0];
    // Shift amounts of 8 or more clear the accumulator.
    assign shift_oob = |imm[7:3];

    // Next-state and next-accumulator decode; only an enabled instruction in READY has effect.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (state_q == StReady && inst_wen) begin
            case (opcode)
                OpNop: acc_d = acc_q;
                OpLdi: acc_d = imm;
                OpAdd: acc_d = acc_q + imm;
                OpSub: acc_d = acc_q - imm;
                OpNot: acc_d = ~acc_q;
                OpAnd: acc_d = acc_q & imm;
                OpIor: acc_d = acc_q | imm;
                OpXor: acc_d = acc_q ^ imm;
                OpShl: acc_d = shift_oob ? 8'h00 : (acc_q << imm[2:0]);
                OpShr: acc_d = shift_oob ? 8'h00 : (acc_q >> imm[2:0]);
                default: begin
                    state_d = StError;
                    acc_d   = acc_q;
                end
            endcase
        end
    end

    // State and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StReady;
            acc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the accumulator ALU: directed scenarios plus a
// randomized run against a behavioural model, using an expected-value queue.
module tb_alu;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] inst;
    logic        inst_wen;
    logic [7:0]  result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp;

    alu dut (
        .clock    (clock),
        .reset    (reset),
        .inst     (inst),
        .inst_wen (inst_wen),
        .result   (result)
    );

    always #5 clock = ~clock;

    // Apply one cycle of stimulus, record what result must be after the edge.
    task automatic drive(input logic rst, input logic wen, input logic [11:0] ins,
                         input logic [7:0] expected);
        reset    = rst;
        inst_wen = wen;
        inst     = ins;
        exp_q.push_back(expected);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 12'h1FF, 8'h00);
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL reset_init: result=%h expected=%h", result, exp);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 12'h1AB, 8'h00);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL reset_hold: result=%h expected=%h", result, exp);
            end
        end
    endtask

    task automatic test_sequence();
        logic [11:0] ins[10] = '{12'h11A, 12'h201, 12'h000, 12'h302, 12'h400,
                                 12'h50F, 12'h6F1, 12'h7AF, 12'h801, 12'h902};
        logic [7:0]  res[10] = '{8'h1A, 8'h1B, 8'h1B, 8'h19, 8'hE6,
                                 8'h06, 8'hF7, 8'h58, 8'hB0, 8'h2C};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, ins[i], res[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL sequence[%0d]: result=%h expected=%h", i, result, exp);
            end
        end
    endtask

    task automatic test_bounds();
        logic [11:0] ins[6] = '{12'h1FF, 12'h201, 12'h301, 12'h808, 12'h180, 12'h907};
        logic [7:0]  res[6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h01};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, ins[i], res[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL bounds[%0d]: result=%h expected=%h", i, result, exp);
            end
        end
        // SHR by >= 8 also clears.
        drive(1'b1, 1'b1, 12'h1C3, 8'hC3);
        drive(1'b1, 1'b1, 12'h90C, 8'h00);
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            if (i == 1) begin
                n_checks++;
                if (result !== exp) begin
                    n_fail++;
                    $display("FAIL shr_oob: result=%h expected=%h", result, exp);
                end
            end
        end
        // Restore acc=2C for the enable test.
        drive(1'b1, 1'b1, 12'h12C, 8'h2C);
        exp = exp_q.pop_front();
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 12'h201, 8'h2C);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL enable_off[%0d]: result=%h expected=%h", i, result, exp);
            end
        end
        drive(1'b1, 1'b0, 12'hF11, 8'h2C);
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL enable_off_invalid: result=%h expected=%h", result, exp);
        end
        drive(1'b1, 1'b1, 12'h201, 8'h2D);
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL enable_on: result=%h expected=%h", result, exp);
        end
    endtask

    task automatic test_error();
        logic [11:0] ins[4] = '{12'hF02, 12'h203, 12'h155, 12'h400};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, ins[i], 8'h2D);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL error_sticky[%0d]: result=%h expected=%h", i, result, exp);
            end
        end
    endtask

    task automatic test_recovery();
        logic       rst[3] = '{1'b0, 1'b1, 1'b1};
        logic [11:0] ins[3] = '{12'h000, 12'h1AA, 12'h000};
        logic [7:0]  res[3] = '{8'h00, 8'hAA, 8'hAA};
        for (int i = 0; i < 3; i++) begin
            drive(rst[i], i != 0, ins[i], res[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL recovery[%0d]: result=%h expected=%h", i, result, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 12'h177, 8'h00);
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL reset_priority: result=%h expected=%h", result, exp);
        end
        // Reset also clears ERROR: an invalid op then reset, then LDI must be accepted.
        drive(1'b1, 1'b1, 12'hB00, 8'h00);
        drive(1'b0, 1'b0, 12'h000, 8'h00);
        drive(1'b1, 1'b1, 12'h142, 8'h42);
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
        end
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL error_reset_clear: result=%h expected=%h", result, exp);
        end
    endtask

    task automatic test_random();
        int         m_acc = 0;
        bit         m_err = 1'b0;
        int         sh;
        logic       rst;
        logic       wen;
        logic [11:0] ins;
        drive(1'b0, 1'b0, 12'h000, 8'h00);
        exp = exp_q.pop_front();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            wen = ($urandom_range(0, 3) != 0);
            ins = 12'($urandom);
            if ($urandom_range(0, 7) != 0) ins[11:8] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0) ins[7:0] = 8'($urandom_range(0, 10));
            sh = int'(ins[7:0]);
            if (!rst) begin
                m_acc = 0;
                m_err = 1'b0;
            end else if (wen && !m_err) begin
                case (int'(ins[11:8]))
                    0: m_acc = m_acc;
                    1: m_acc = sh;
                    2: m_acc = (m_acc + sh) % 256;
                    3: m_acc = (m_acc - sh + 256) % 256;
                    4: m_acc = 255 - m_acc;
                    5: m_acc = m_acc & sh;
                    6: m_acc = m_acc | sh;
                    7: m_acc = m_acc ^ sh;
                    8: m_acc = (sh >= 8) ? 0 : ((m_acc * (1 << sh)) % 256);
                    9: m_acc = (sh >= 8) ? 0 : (m_acc / (1 << sh));
                    default: m_err = 1'b1;
                endcase
            end
            drive(rst, wen, ins, 8'(m_acc));
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] inst=%h wen=%0b rst=%0b: result=%h expected=%h",
                         i, ins, wen, rst, result, exp);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        inst_wen = 1'b0;
        inst     = 12'h000;
        test_reset();
        test_sequence();
        test_bounds();
        test_enable();
        test_error();
        test_recovery();
        test_reset_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
